// File: rtl/duck_motion_ctl.sv
// Per-frame motion/animation controller for one duck sprite: launch, bounce, hit, fall, escape.
// Build option DUCK_RANDOM_DIR_EN: launch direction taken from an internal LFSR instead of dir_init.
module duck_motion_ctl #(
    parameter int SCREEN_W   = 800,
    parameter int SPRITE_W   = 48,
    parameter int SPRITE_H   = 64,
    parameter int GROUND_Y   = 450,
    parameter int START_X    = 376,
    parameter int SPEED_X    = 2,
    parameter int SPEED_Y    = 2,
    parameter int FALL_SPEED = 4,
    parameter int FLY_FRAMES = 600,
    parameter int HIT_FRAMES = 30,
    parameter int ANIM_DIV   = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        hit,
    input  logic [1:0]  dir_init,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        invert,
    output logic [1:0]  anim_frame,
    output logic        visible,
    output logic        busy,
    output logic        escaped,
    output logic        fell
);

    localparam logic [10:0] XMAX = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0] YMAX = 11'(GROUND_Y - SPRITE_H);
    localparam logic [10:0] X0   = 11'(START_X);
    localparam logic [10:0] SPX  = 11'(SPEED_X);
    localparam logic [10:0] SPY  = 11'(SPEED_Y);
    localparam logic [10:0] SPF  = 11'(FALL_SPEED);

    localparam int FW = $clog2(FLY_FRAMES + 1);
    localparam int HW = $clog2(HIT_FRAMES + 1);
    localparam int DW = $clog2(ANIM_DIV + 1);
    localparam logic [FW-1:0] FLY_LAST = FW'(FLY_FRAMES - 1);
    localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLY,
        S_HIT,
        S_FALL,
        S_ESCAPE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic            left_q, left_d, up_q, up_d;
    logic [FW-1:0]   fly_cnt_q, fly_cnt_d;
    logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      anim_q, anim_d;
    logic            pend_q, pend_d;
    logic            visible_q, visible_d, busy_q, busy_d;
    logic            escaped_q, escaped_d, fell_q, fell_d;
    logic [1:0]      launch_dir;

`ifdef DUCK_RANDOM_DIR_EN
    logic [15:0] lfsr_q;
    logic        unused_dir_init;

    assign unused_dir_init = ^dir_init;

    // Taps 16,14,13,11; free-running so launch direction depends on start timing.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign launch_dir = lfsr_q[1:0];
`else
    assign launch_dir = dir_init;
`endif

    // Horizontal bounce and animation step are shared by FLY and ESCAPE.
    logic [10:0]   x_step;
    logic          left_step;
    logic [DW-1:0] div_step;
    logic [1:0]    anim_step;

    always_comb begin
        x_step    = x_q;
        left_step = left_q;
        if (!left_q) begin
            if (x_q + SPX >= XMAX) begin
                x_step    = XMAX;
                left_step = 1'b1;
            end else begin
                x_step = x_q + SPX;
            end
        end else begin
            if (x_q <= SPX) begin
                x_step    = '0;
                left_step = 1'b0;
            end else begin
                x_step = x_q - SPX;
            end
        end

        div_step  = div_q + 1'b1;
        anim_step = anim_q;
        if (div_q == DIV_LAST) begin
            div_step  = '0;
            anim_step = (anim_q == 2'd2) ? 2'd0 : anim_q + 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        left_d    = left_q;
        up_d      = up_q;
        fly_cnt_d = fly_cnt_q;
        hit_cnt_d = hit_cnt_q;
        div_d     = div_q;
        anim_d    = anim_q;
        pend_d    = pend_q;
        visible_d = visible_q;
        escaped_d = 1'b0;
        fell_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_FLY;
                    x_d       = X0;
                    y_d       = YMAX;
                    left_d    = ~launch_dir[0];
                    up_d      = launch_dir[1];
                    fly_cnt_d = '0;
                    div_d     = '0;
                    anim_d    = 2'd0;
                    pend_d    = 1'b0;
                    visible_d = 1'b1;
                end
            end
            S_FLY: begin
                if (hit) pend_d = 1'b1;
                if (frame_tick) begin
                    if (pend_q) begin
                        state_d   = S_HIT;
                        anim_d    = 2'd3;
                        hit_cnt_d = '0;
                        pend_d    = 1'b0;
                    end else begin
                        x_d    = x_step;
                        left_d = left_step;
                        div_d  = div_step;
                        anim_d = anim_step;
                        if (up_q) begin
                            if (y_q <= SPY) begin
                                y_d  = '0;
                                up_d = 1'b0;
                            end else begin
                                y_d = y_q - SPY;
                            end
                        end else begin
                            if (y_q + SPY >= YMAX) begin
                                y_d  = YMAX;
                                up_d = 1'b1;
                            end else begin
                                y_d = y_q + SPY;
                            end
                        end
                        if (fly_cnt_q == FLY_LAST) state_d = S_ESCAPE;
                        else                        fly_cnt_d = fly_cnt_q + 1'b1;
                    end
                end
            end
            S_HIT: begin
                if (frame_tick) begin
                    if (hit_cnt_q == HIT_LAST) state_d = S_FALL;
                    else                        hit_cnt_d = hit_cnt_q + 1'b1;
                end
            end
            S_FALL: begin
                if (frame_tick) begin
                    if (y_q + SPF >= YMAX) begin
                        y_d       = YMAX;
                        fell_d    = 1'b1;
                        visible_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        y_d = y_q + SPF;
                    end
                end
            end
            S_ESCAPE: begin
                if (frame_tick) begin
                    x_d    = x_step;
                    left_d = left_step;
                    div_d  = div_step;
                    anim_d = anim_step;
                    if (y_q <= SPY) begin
                        y_d       = '0;
                        escaped_d = 1'b1;
                        visible_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        y_d = y_q - SPY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= X0;
            y_q       <= YMAX;
            left_q    <= 1'b0;
            up_q      <= 1'b0;
            fly_cnt_q <= '0;
            hit_cnt_q <= '0;
            div_q     <= '0;
            anim_q    <= 2'd0;
            pend_q    <= 1'b0;
            visible_q <= 1'b0;
            busy_q    <= 1'b0;
            escaped_q <= 1'b0;
            fell_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            left_q    <= left_d;
            up_q      <= up_d;
            fly_cnt_q <= fly_cnt_d;
            hit_cnt_q <= hit_cnt_d;
            div_q     <= div_d;
            anim_q    <= anim_d;
            pend_q    <= pend_d;
            visible_q <= visible_d;
            busy_q    <= busy_d;
            escaped_q <= escaped_d;
            fell_q    <= fell_d;
        end
    end

    assign xpos       = x_q;
    assign ypos       = y_q;
    assign invert     = left_q;
    assign anim_frame = anim_q;
    assign visible    = visible_q;
    assign busy       = busy_q;
    assign escaped    = escaped_q;
    assign fell       = fell_q;

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Directed bench for duck_motion_ctl: flight table, hit/fall, hit-vs-timeout and mid-fall reset.
module tb_duck_motion_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic [1:0]  dir_init = 2'b11;
    logic [10:0] xpos, ypos;
    logic        invert, visible, busy, escaped, fell;
    logic [1:0]  anim_frame;

    duck_motion_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .hit        (hit),
        .dir_init   (dir_init),
        .xpos       (xpos),
        .ypos       (ypos),
        .invert     (invert),
        .anim_frame (anim_frame),
        .visible    (visible),
        .busy       (busy),
        .escaped    (escaped),
        .fell       (fell)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;
    int esc_cnt = 0;
    int esc_base;

    always @(negedge pclk) if (escaped === 1'b1) esc_cnt++;

    typedef struct {
        int n;
        int x;
        int y;
        int inv;
        int anim;
        int vis;
        int busy;
        int esc;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk) frame_tick = 1'b1;
        @(negedge pclk) frame_tick = 1'b0;
        ticks++;
    endtask

    task automatic ticks_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1; start = 1'b0; hit = 1'b0; frame_tick = 1'b0;
        @(negedge pclk);
        @(negedge pclk) rst = 1'b0;
        ticks = 0;
    endtask

    task automatic launch();
        @(negedge pclk) start = 1'b1;
        @(negedge pclk) start = 1'b0;
    endtask

    task automatic pulse_hit();
        @(negedge pclk) hit = 1'b1;
        @(negedge pclk) hit = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int anim);
        chk({tag, " x"}, 32'(xpos), 32'(x));
        chk({tag, " y"}, 32'(ypos), 32'(y));
        chk({tag, " anim"}, 32'(anim_frame), 32'(anim));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " x"}, 32'(xpos), 32'd376);
        chk({tag, " y"}, 32'(ypos), 32'd386);
        chk({tag, " invert"}, 32'(invert), 32'd0);
        chk({tag, " anim"}, 32'(anim_frame), 32'd0);
        chk({tag, " visible"}, 32'(visible), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " escaped"}, 32'(escaped), 32'd0);
        chk({tag, " fell"}, 32'(fell), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // n: cumulative ticks since launch (dir up+right, no hit)
        tbl[0]  = '{1,   378, 384, 0, 0, 1, 1, 0};
        tbl[1]  = '{8,   392, 370, 0, 1, 1, 1, 0};
        tbl[2]  = '{24,  424, 338, 0, 0, 1, 1, 0};
        tbl[3]  = '{187, 750, 12,  0, 2, 1, 1, 0};
        tbl[4]  = '{188, 752, 10,  1, 2, 1, 1, 0};
        tbl[5]  = '{189, 750, 8,   1, 2, 1, 1, 0};
        tbl[6]  = '{193, 742, 0,   1, 0, 1, 1, 0};
        tbl[7]  = '{194, 740, 2,   1, 0, 1, 1, 0};
        tbl[8]  = '{386, 356, 386, 1, 0, 1, 1, 0};
        tbl[9]  = '{564, 0,   30,  0, 1, 1, 1, 0};
        tbl[10] = '{600, 72,  42,  0, 0, 1, 1, 0};
        tbl[11] = '{620, 112, 2,   0, 2, 1, 1, 0};
        tbl[12] = '{621, 114, 0,   0, 2, 0, 0, 1};

        // Scenario 1: reset, free flight through timeout and escape
        do_reset();
        chk_reset_vals("reset");
        launch();
        chk("launch visible", 32'(visible), 32'd1);
        chk("launch busy", 32'(busy), 32'd1);
        chk("launch x", 32'(xpos), 32'd376);
        @(negedge pclk);
        @(negedge pclk);
        chk("no tick hold y", 32'(ypos), 32'd386);
        for (int i = 0; i < 13; i++) begin
            while (ticks < tbl[i].n) tick();
            chk($sformatf("t%0d x", tbl[i].n), 32'(xpos), 32'(tbl[i].x));
            chk($sformatf("t%0d y", tbl[i].n), 32'(ypos), 32'(tbl[i].y));
            chk($sformatf("t%0d invert", tbl[i].n), 32'(invert), 32'(tbl[i].inv));
            chk($sformatf("t%0d anim", tbl[i].n), 32'(anim_frame), 32'(tbl[i].anim));
            chk($sformatf("t%0d visible", tbl[i].n), 32'(visible), 32'(tbl[i].vis));
            chk($sformatf("t%0d busy", tbl[i].n), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t%0d escaped", tbl[i].n), 32'(escaped), 32'(tbl[i].esc));
        end
        @(negedge pclk);
        chk("escaped one cycle", 32'(escaped), 32'd0);

        // Scenario 2: hit after 10 ticks, freeze, fall to floor
        do_reset();
        launch();
        ticks_n(10);
        chk_pos("pre-hit", 396, 366, 1);
        pulse_hit();
        chk_pos("hit pending", 396, 366, 1);
        tick();
        chk_pos("hit entry", 396, 366, 3);
        chk("hit busy", 32'(busy), 32'd1);
        chk("hit visible", 32'(visible), 32'd1);
        ticks_n(29);
        chk_pos("hit 29", 396, 366, 3);
        tick();
        chk_pos("hit 30", 396, 366, 3);
        tick();
        chk_pos("fall 1", 396, 370, 3);
        ticks_n(3);
        chk_pos("fall 4", 396, 382, 3);
        chk("fall 4 fell", 32'(fell), 32'd0);
        tick();
        chk_pos("fall done", 396, 386, 3);
        chk("fall done fell", 32'(fell), 32'd1);
        chk("fall done visible", 32'(visible), 32'd0);
        chk("fall done busy", 32'(busy), 32'd0);
        @(negedge pclk);
        chk("fell one cycle", 32'(fell), 32'd0);

        // Scenario 3: pending hit on the timeout tick, then reset mid-fall
        do_reset();
        launch();
        ticks_n(599);
        chk_pos("t599", 70, 40, 2);
        esc_base = esc_cnt;
        pulse_hit();
        tick();
        chk_pos("hit at timeout", 70, 40, 3);
        chk("hit at timeout busy", 32'(busy), 32'd1);
        ticks_n(25);
        chk("no escape y", 32'(ypos), 32'd40);
        chk("no escape busy", 32'(busy), 32'd1);
        ticks_n(10);
        chk_pos("mid fall", 70, 60, 3);
        chk("escaped never pulsed", 32'(esc_cnt - esc_base), 32'd0);
        @(negedge pclk) rst = 1'b1;
        #1;
        chk_reset_vals("mid-fall reset");
        @(negedge pclk) rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
